// File: rtl/ac_motor_pkg.sv
// Shared definitions for the AC motor blocks: the 12-bit frequency/amplitude
// width and the 3-bit FSM state encodings, which are also visible on the
// debug state port.
package ac_motor_pkg;

   localparam int AMP_W = 12;
   localparam logic [AMP_W-1:0] AMP_MAX = {AMP_W{1'b1}};

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RAMP  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_FAULT = 3'd4;

endpackage

// File: rtl/ac_motor_vf_map.sv
// V/f mapping: u = min(4095, (frequency * VF_NUM) >> 8), with the product
// kept at 21 bits so no term is lost before saturation.
// Optional feature: define AC_MOTOR_VF_BOOST_EN to add U_BOOST to the
// amplitude whenever frequency is non-zero (saturating at 4095).
module ac_motor_vf_map
   import ac_motor_pkg::*;
#(
   parameter int unsigned VF_NUM  = 256
`ifdef AC_MOTOR_VF_BOOST_EN
   ,
   parameter int unsigned U_BOOST = 128
`endif
) (
   input  logic [AMP_W-1:0] frequency,
   output logic [AMP_W-1:0] u_map
);

   localparam logic [8:0] VF_GAIN = 9'(VF_NUM);

   logic [20:0] product;
   logic [13:0] scaled;

   // Multiply, drop the implicit /256, optionally boost, then saturate.
   always_comb begin
      product = 21'(frequency) * 21'(VF_GAIN);
      scaled  = 14'(product >> 8);
`ifdef AC_MOTOR_VF_BOOST_EN
      if (frequency != '0) begin
         scaled = scaled + 14'(U_BOOST);
      end
`endif
      u_map = (scaled > 14'(AMP_MAX)) ? AMP_MAX : scaled[AMP_W-1:0];
   end

endmodule

// File: rtl/ac_motor_ramp_control.sv
// Frequency ramp controller for an AC motor drive. Ramps the output frequency
// toward f_target in F_STEP increments every RAMP_DIV clocks, ramps down to
// zero on stop, and drops to zero immediately on fault. The amplitude u_str
// follows frequency through the V/f map, one cycle behind.
// Optional feature: AC_MOTOR_VF_BOOST_EN enables a low-speed voltage boost.
module ac_motor_ramp_control
   import ac_motor_pkg::*;
#(
   parameter int unsigned RAMP_DIV = 1000,
   parameter int unsigned F_STEP   = 1,
   parameter int unsigned VF_NUM   = 256
`ifdef AC_MOTOR_VF_BOOST_EN
   ,
   parameter int unsigned U_BOOST  = 128
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             fault,
   input  logic [AMP_W-1:0] f_target,
   output logic [AMP_W-1:0] frequency,
   output logic [AMP_W-1:0] u_str,
   output logic             running,
   output logic [2:0]       state
);

   localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
   localparam logic [AMP_W:0]    STEP      = (AMP_W + 1)'(F_STEP);

   logic [2:0]        state_nxt;
   logic [AMP_W-1:0]  freq_nxt;
   logic [TICK_W-1:0] tick;
   logic [TICK_W-1:0] tick_nxt;
   logic [AMP_W-1:0]  toward;
   logic [AMP_W-1:0]  down0;
   logic [AMP_W-1:0]  u_map;
   logic [AMP_W:0]    freq_w;
   logic [AMP_W:0]    tgt_w;

   ac_motor_vf_map #(
      .VF_NUM    (VF_NUM)
`ifdef AC_MOTOR_VF_BOOST_EN
      ,
      .U_BOOST   (U_BOOST)
`endif
   ) u_vf_map (
      .frequency (frequency),
      .u_map     (u_map)
   );

   // One ramp step toward the target (clamped) and one step toward zero.
   always_comb begin
      freq_w = {1'b0, frequency};
      tgt_w  = {1'b0, f_target};
      if (freq_w < tgt_w) begin
         toward = (freq_w + STEP >= tgt_w) ? f_target : AMP_W'(freq_w + STEP);
      end else begin
         toward = (freq_w >= tgt_w + STEP) ? AMP_W'(freq_w - STEP) : f_target;
      end
      down0 = (freq_w > STEP) ? AMP_W'(freq_w - STEP) : '0;
   end

   // Next-state, next-frequency and tick logic; priority fault > stop > start.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_nxt = state;
      freq_nxt  = frequency;
      tick_nxt  = '0;
      if (fault) begin
         state_nxt = ST_FAULT;
         freq_nxt  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !stop) state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
               if (stop || !start) begin
                  state_nxt = ST_STOP;
               end else if (frequency == f_target) begin
                  state_nxt = ST_RUN;
               end else if (tick == TICK_LAST) begin
                  freq_nxt = toward;
                  if (toward == f_target) state_nxt = ST_RUN;
               end else begin
                  tick_nxt = tick + 1'b1;
               end
            end
            ST_RUN: begin
               if (stop || !start)             state_nxt = ST_STOP;
               else if (f_target != frequency) state_nxt = ST_RAMP;
            end
            ST_STOP: begin
               if (start && !stop) begin
                  state_nxt = ST_RAMP;
               end else if (frequency == '0) begin
                  state_nxt = ST_IDLE;
               end else if (tick == TICK_LAST) begin
                  freq_nxt = down0;
               end else begin
                  tick_nxt = tick + 1'b1;
               end
            end
            ST_FAULT: begin
               if (!start) state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
               freq_nxt  = '0;
            end
         endcase
      end
   end

   // State, frequency, tick and amplitude registers with async reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         frequency <= '0;
         tick      <= '0;
         u_str     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state     <= state_nxt;
         frequency <= freq_nxt;
         tick      <= tick_nxt;
         u_str     <= (state_nxt == ST_IDLE || state_nxt == ST_FAULT) ? '0 : u_map;
      end
   end

   // Switch control is enabled only while the motor is being driven.
   always_comb begin
      running = (state == ST_RAMP) || (state == ST_RUN);
   end

endmodule

// File: tb/tb_ac_motor_ramp_control.sv
// Self-checking bench for ac_motor_ramp_control: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_ac_motor_ramp_control;

   localparam int RAMP_DIV = 4;
   localparam int F_STEP   = 16;
   localparam int VF_NUM   = 256;
   localparam int VF_SAT   = 511;

   localparam int S_IDLE = 0, S_RAMP = 1, S_RUN = 2, S_STOP = 3, S_FAULT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, stop, fault;
   logic [11:0] f_target;
   logic [11:0] frequency, u_str;
   logic        running;
   logic [2:0]  state;

   logic        s_start, s_stop, s_fault;
   logic [11:0] s_target;
   logic [11:0] s_frequency, s_u_str;
   logic        s_running;
   logic [2:0]  s_state;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state (main DUT only).
   int m_state = 0, m_freq = 0, m_tick = 0, m_ustr = 0;
   int ns, nf, nt, nu;

   always #5 clk = ~clk;

   ac_motor_ramp_control #(
      .RAMP_DIV (RAMP_DIV),
      .F_STEP   (F_STEP),
      .VF_NUM   (VF_NUM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .fault     (fault),
      .f_target  (f_target),
      .frequency (frequency),
      .u_str     (u_str),
      .running   (running),
      .state     (state)
   );

   ac_motor_ramp_control #(
      .RAMP_DIV (RAMP_DIV),
      .F_STEP   (F_STEP),
      .VF_NUM   (VF_SAT)
   ) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .start     (s_start),
      .stop      (s_stop),
      .fault     (s_fault),
      .f_target  (s_target),
      .frequency (s_frequency),
      .u_str     (s_u_str),
      .running   (s_running),
      .state     (s_state)
   );

   function automatic int vf(input int f, input int num);
      int v;
      v = (f * num) / 256;
`ifdef AC_MOTOR_VF_BOOST_EN
      if (f > 0) v = v + 128;
`endif
      return (v > 4095) ? 4095 : v;
   endfunction

   // Reference rules: one evaluation per clock from the current inputs.
   task automatic model_next(output int o_s, output int o_f, output int o_t, output int o_u);
      int tgt;
      tgt = int'(f_target);
      o_s = m_state;
      o_f = m_freq;
      o_t = 0;
      if (fault) begin
         o_s = S_FAULT;
         o_f = 0;
      end else if (m_state == S_IDLE) begin
         if (start && !stop) o_s = S_RAMP;
      end else if (m_state == S_RAMP) begin
         if (stop || !start) o_s = S_STOP;
         else if (m_freq == tgt) o_s = S_RUN;
         else if (m_tick == RAMP_DIV - 1) begin
            if (m_freq < tgt) o_f = (m_freq + F_STEP > tgt) ? tgt : m_freq + F_STEP;
            else              o_f = (m_freq - F_STEP < tgt) ? tgt : m_freq - F_STEP;
            if (o_f == tgt) o_s = S_RUN;
         end else o_t = m_tick + 1;
      end else if (m_state == S_RUN) begin
         if (stop || !start) o_s = S_STOP;
         else if (tgt != m_freq) o_s = S_RAMP;
      end else if (m_state == S_STOP) begin
         if (start && !stop) o_s = S_RAMP;
         else if (m_freq == 0) o_s = S_IDLE;
         else if (m_tick == RAMP_DIV - 1) o_f = (m_freq > F_STEP) ? m_freq - F_STEP : 0;
         else o_t = m_tick + 1;
      end else begin
         if (!start) o_s = S_IDLE;
      end
      o_u = (o_s == S_IDLE || o_s == S_FAULT) ? 0 : vf(m_freq, VF_NUM);
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_state <= S_IDLE;
         m_freq  <= 0;
         m_tick  <= 0;
         m_ustr  <= 0;
      end else begin
         model_next(ns, nf, nt, nu);
         m_state <= ns;
         m_freq  <= nf;
         m_tick  <= nt;
         m_ustr  <= nu;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cyc(3);
      n_cmp++; if (state !== 3'd0)      begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
      n_cmp++; if (frequency !== 12'd0) begin n_bad++; $display("FAIL reset_freq: got %0d expected 0", frequency); end
      n_cmp++; if (u_str !== 12'd0)     begin n_bad++; $display("FAIL reset_ustr: got %0d expected 0", u_str); end
      n_cmp++; if (running !== 1'b0)    begin n_bad++; $display("FAIL reset_running: got %0d expected 0", running); end
      reset = 1'b0;
      cyc(2);
      n_cmp++; if (state !== 3'd0)      begin n_bad++; $display("FAIL post_reset_idle: got %0d expected 0", state); end
   endtask

   task automatic test_ramp_up();
      start = 1'b1; f_target = 12'd64;
      cyc(1);
      n_cmp++; if (state !== 3'd1)   begin n_bad++; $display("FAIL ramp_enter: got %0d expected 1", state); end
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL ramp_running: got %0d expected 1", running); end
      for (int k = 1; k <= 4; k++) begin
         cyc(4);
         n_cmp++; if (frequency !== 12'(16 * k)) begin n_bad++; $display("FAIL ramp_step%0d: got %0d expected %0d", k, frequency, 16 * k); end
         n_cmp++; if (u_str !== 12'(vf(16 * (k - 1), VF_NUM))) begin n_bad++; $display("FAIL ramp_ustr%0d: got %0d expected %0d", k, u_str, vf(16 * (k - 1), VF_NUM)); end
         n_cmp++; if (state !== ((k == 4) ? 3'd2 : 3'd1)) begin n_bad++; $display("FAIL ramp_state%0d: got %0d expected %0d", k, state, (k == 4) ? 2 : 1); end
      end
      cyc(1);
      n_cmp++; if (u_str !== 12'(vf(64, VF_NUM))) begin n_bad++; $display("FAIL run_ustr: got %0d expected %0d", u_str, vf(64, VF_NUM)); end
   endtask

   task automatic test_stop();
      stop = 1'b1;
      cyc(1);
      n_cmp++; if (state !== 3'd3)   begin n_bad++; $display("FAIL stop_enter: got %0d expected 3", state); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL stop_running: got %0d expected 0", running); end
      for (int k = 1; k <= 4; k++) begin
         cyc(4);
         n_cmp++; if (frequency !== 12'(64 - 16 * k)) begin n_bad++; $display("FAIL stop_step%0d: got %0d expected %0d", k, frequency, 64 - 16 * k); end
      end
      cyc(1);
      n_cmp++; if (state !== 3'd0)   begin n_bad++; $display("FAIL stop_idle: got %0d expected 0", state); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL stop_idle_running: got %0d expected 0", running); end
      n_cmp++; if (u_str !== 12'd0)  begin n_bad++; $display("FAIL stop_idle_ustr: got %0d expected 0", u_str); end
      stop = 1'b0; start = 1'b0;
      cyc(1);
   endtask

   task automatic test_clamp();
      int up_seq [3]   = '{16, 32, 40};
      int down_seq [3] = '{24, 8, 0};
      start = 1'b1; f_target = 12'd0;
      cyc(2);
      n_cmp++; if (state !== 3'd2)      begin n_bad++; $display("FAIL zero_run_state: got %0d expected 2", state); end
      n_cmp++; if (frequency !== 12'd0) begin n_bad++; $display("FAIL zero_run_freq: got %0d expected 0", frequency); end
      n_cmp++; if (running !== 1'b1)    begin n_bad++; $display("FAIL zero_run_running: got %0d expected 1", running); end
      f_target = 12'd40;
      cyc(1);
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL retarget_ramp: got %0d expected 1", state); end
      for (int k = 0; k < 3; k++) begin
         cyc(4);
         n_cmp++; if (frequency !== 12'(up_seq[k])) begin n_bad++; $display("FAIL clamp_up%0d: got %0d expected %0d", k, frequency, up_seq[k]); end
      end
      n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL clamp_run: got %0d expected 2", state); end
      cyc(1);
      n_cmp++; if (u_str !== 12'(vf(40, VF_NUM))) begin n_bad++; $display("FAIL clamp_ustr: got %0d expected %0d", u_str, vf(40, VF_NUM)); end
      f_target = 12'd0;
      cyc(1);
      for (int k = 0; k < 3; k++) begin
         cyc(4);
         n_cmp++; if (frequency !== 12'(down_seq[k])) begin n_bad++; $display("FAIL clamp_down%0d: got %0d expected %0d", k, frequency, down_seq[k]); end
      end
      n_cmp++; if (state !== 3'd2)   begin n_bad++; $display("FAIL down_zero_run: got %0d expected 2", state); end
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL down_zero_running: got %0d expected 1", running); end
   endtask

   task automatic test_fault();
      f_target = 12'd64;
      cyc(6);
      n_cmp++; if (frequency !== 12'd16) begin n_bad++; $display("FAIL fault_pre_freq: got %0d expected 16", frequency); end
      fault = 1'b1;
      cyc(1);
      n_cmp++; if (state !== 3'd4)      begin n_bad++; $display("FAIL fault_state: got %0d expected 4", state); end
      n_cmp++; if (frequency !== 12'd0) begin n_bad++; $display("FAIL fault_freq: got %0d expected 0", frequency); end
      n_cmp++; if (u_str !== 12'd0)     begin n_bad++; $display("FAIL fault_ustr: got %0d expected 0", u_str); end
      n_cmp++; if (running !== 1'b0)    begin n_bad++; $display("FAIL fault_running: got %0d expected 0", running); end
      fault = 1'b0;
      cyc(3);
      n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL fault_latch: got %0d expected 4", state); end
      start = 1'b0;
      cyc(1);
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL fault_exit: got %0d expected 0", state); end
   endtask

   task automatic test_start_stop_idle();
      start = 1'b1; stop = 1'b1; f_target = 12'd100;
      cyc(5);
      n_cmp++; if (state !== 3'd0)   begin n_bad++; $display("FAIL start_stop_idle: got %0d expected 0", state); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL start_stop_running: got %0d expected 0", running); end
      start = 1'b0; stop = 1'b0;
      cyc(1);
   endtask

   task automatic test_reset_mid_ramp();
      start = 1'b1; f_target = 12'd100;
      cyc(7);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (state !== 3'd0)      begin n_bad++; $display("FAIL async_reset_state: got %0d expected 0", state); end
      n_cmp++; if (frequency !== 12'd0) begin n_bad++; $display("FAIL async_reset_freq: got %0d expected 0", frequency); end
      start = 1'b0;
      cyc(2);
      reset = 1'b0;
      cyc(3);
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL restart_needs_start: got %0d expected 0", state); end
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 999);
         if (r < 20)       start = ~start;
         else if (r < 30)  stop = 1'b1;
         else if (r < 34)  fault = 1'b1;
         else if (r < 60)  f_target = 12'($urandom_range(0, 320));
         if (stop && $urandom_range(0, 9) < 3)  stop = 1'b0;
         if (fault && $urandom_range(0, 9) < 3) fault = 1'b0;
         cyc(1);
         n_cmp++; if (state !== 3'(m_state))     begin n_bad++; $display("FAIL rnd_state c=%0d: got %0d expected %0d", c, state, m_state); end
         n_cmp++; if (frequency !== 12'(m_freq)) begin n_bad++; $display("FAIL rnd_freq c=%0d: got %0d expected %0d", c, frequency, m_freq); end
         n_cmp++; if (u_str !== 12'(m_ustr))     begin n_bad++; $display("FAIL rnd_ustr c=%0d: got %0d expected %0d", c, u_str, m_ustr); end
         n_cmp++; if (running !== (m_state == S_RAMP || m_state == S_RUN)) begin n_bad++; $display("FAIL rnd_running c=%0d: got %0d", c, running); end
      end
   endtask

   task automatic test_saturation();
      bit reached;
      s_start = 1'b1; s_target = 12'd4095;
      cyc(5);
      n_cmp++; if (s_frequency !== 12'd16) begin n_bad++; $display("FAIL sat_first_step: got %0d expected 16", s_frequency); end
      cyc(1);
      n_cmp++; if (s_u_str !== 12'(vf(16, VF_SAT))) begin n_bad++; $display("FAIL sat_ustr16: got %0d expected %0d", s_u_str, vf(16, VF_SAT)); end
      reached = 1'b0;
      for (int c = 0; c < 3000 && !reached; c++) begin
         cyc(1);
         if (s_state == 3'd2) reached = 1'b1;
      end
      n_cmp++; if (!reached) begin n_bad++; $display("FAIL sat_reach_run: got state %0d expected 2 within bound", s_state); end
      n_cmp++; if (s_frequency !== 12'd4095) begin n_bad++; $display("FAIL sat_freq: got %0d expected 4095", s_frequency); end
      cyc(1);
      n_cmp++; if (s_u_str !== 12'd4095) begin n_bad++; $display("FAIL sat_ustr: got %0d expected 4095", s_u_str); end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0; stop = 1'b0; fault = 1'b0; f_target = 12'd0;
      s_start = 1'b0; s_stop = 1'b0; s_fault = 1'b0; s_target = 12'd0;
      test_reset();
      test_ramp_up();
      test_stop();
      test_clamp();
      test_fault();
      test_start_stop_idle();
      test_reset_mid_ramp();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
